// File: rtl/alpaca_ospfb_utils_pkg.sv
// Shared OSPFB constants and types: frame geometry, phase-state count, read FSM states.
package alpaca_ospfb_utils_pkg;

  localparam int WIDTH   = 16;
  localparam int FFT_LEN = 64;
  localparam int DEC_FAC = 48;

  localparam int ADDR_W = $clog2(FFT_LEN);

  function automatic int gcd(input int a, input int b);
    int x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = y;
      y = x % y;
      x = t;
    end
    return x;
  endfunction

  // Number of distinct rotation offsets before the shift sequence repeats.
  localparam int NUM_PHASE_STATES = FFT_LEN / gcd(FFT_LEN, DEC_FAC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } rd_state_t;

endpackage

// File: rtl/phasecomp_buffer_if.sv
// Sample stream interface; master drives data/valid/last, slave drives ready.
interface phasecomp_buffer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/phasecomp_buffer_bank.sv
// Two-bank sample store: simple dual-port RAM, bank bit is the address MSB, 1-cycle registered read.
module phasecomp_bank #(
  parameter int WIDTH = 16,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // The reader may prime a bank in the very cycle its last sample lands,
  // so a same-address collision returns the incoming word.
  always_ff @(posedge clk) begin
    if (!rst)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end
endmodule

// File: rtl/phasecomp_buffer.sv
// Ping-pong phase-compensation buffer: frames are written rotated by a rolling offset and read out in order.
// Optional PHASECOMP_BYPASS_EN adds a per-frame 'bypass' input that writes a frame unrotated.
module phasecomp_buffer
  import alpaca_ospfb_utils_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
`ifdef PHASECOMP_BYPASS_EN
  input  logic               bypass,
`endif
  phasecomp_buffer_if.slave  s_axis,
  phasecomp_buffer_if.master m_axis
);
  localparam int                DEC_MOD    = DEC_FAC % FFT_LEN;
  localparam logic [ADDR_W-1:0] SHIFT_STEP = ADDR_W'(DEC_MOD);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FFT_LEN - 1);

  logic [1:0]        full, full_nxt;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_idx, shift, wr_off, wr_slot;
  logic              wr_en, wr_wrap;

  rd_state_t         state, state_nxt;
  logic              rd_bank, rd_bank_nxt;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic              rd_en, rd_clear, other_full;

  // ---------------- write side ----------------
  assign s_axis.tready = rst & ~full[wr_bank];
  assign wr_en         = s_axis.tvalid & s_axis.tready;
  assign wr_wrap       = wr_en & (wr_idx == LAST_ADDR);

`ifdef PHASECOMP_BYPASS_EN
  logic byp_q, byp_cur;
  // First sample of a frame sees the live input; the rest use the latched choice.
  assign byp_cur = (wr_idx == '0) ? bypass : byp_q;
  assign wr_off  = byp_cur ? '0 : shift;

  always_ff @(posedge clk) begin
    if (!rst)
      byp_q <= 1'b0;
    else if (wr_en && (wr_idx == '0))
      byp_q <= bypass;
  end
`else
  assign wr_off = shift;
`endif

  assign wr_slot = wr_idx + wr_off;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
      shift   <= '0;
    end else if (wr_en) begin
      wr_idx <= wr_idx + ADDR_W'(1);
      if (wr_wrap) begin
        wr_bank <= ~wr_bank;
        shift   <= shift + SHIFT_STEP;
      end
    end
  end

  // Writer only ever sets a bank that is empty and the reader only clears a full one,
  // so the two updates never target the same bit.
  always_comb begin
    full_nxt = full;
    if (rd_clear) full_nxt[rd_bank] = 1'b0;
    if (wr_wrap)  full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) full <= '0;
    else      full <= full_nxt;
  end

  // ---------------- read side ----------------
  // Lookahead on the other bank keeps frames back-to-back when it fills on the tlast cycle.
  assign other_full = full[~rd_bank] | (wr_wrap & (wr_bank != rd_bank));

  always_comb begin
    state_nxt   = state;
    rd_bank_nxt = rd_bank;
    rd_ptr_nxt  = rd_ptr;
    rd_en       = 1'b0;
    rd_clear    = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_bank]) state_nxt = PRIME;
      end
      PRIME: begin
        rd_en      = 1'b1;
        rd_ptr_nxt = '0;
        state_nxt  = STREAM;
      end
      STREAM: begin
        if (m_axis.tready) begin
          if (rd_ptr == LAST_ADDR) begin
            rd_clear    = 1'b1;
            rd_bank_nxt = ~rd_bank;
            rd_ptr_nxt  = '0;
            if (other_full) rd_en     = 1'b1;
            else            state_nxt = IDLE;
          end else begin
            rd_en      = 1'b1;
            rd_ptr_nxt = rd_ptr + ADDR_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
      rd_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      rd_bank <= rd_bank_nxt;
      rd_ptr  <= rd_ptr_nxt;
    end
  end

  assign m_axis.tvalid = (state == STREAM);
  assign m_axis.tlast  = (state == STREAM) && (rd_ptr == LAST_ADDR);

  phasecomp_bank #(
    .WIDTH (WIDTH),
    .AW    (ADDR_W + 1)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank, wr_slot}),
    .wr_data (s_axis.tdata),
    .rd_en   (rd_en),
    .rd_addr ({rd_bank_nxt, rd_ptr_nxt}),
    .rd_data (m_axis.tdata)
  );
endmodule

// File: tb/tb_phasecomp_buffer.sv
// Bench for phasecomp_buffer: random-handshake stimulus against a frame-gather reference model.
module tb_phasecomp_buffer;
  import alpaca_ospfb_utils_pkg::*;
  localparam int N = FFT_LEN;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  phasecomp_buffer_if #(.WIDTH(WIDTH)) s_if ();
  phasecomp_buffer_if #(.WIDTH(WIDTH)) m_if ();
`ifdef PHASECOMP_BYPASS_EN
  logic bypass = 1'b0;
`endif

  phasecomp_buffer dut (
    .clk    (clk),
    .rst    (rst),
`ifdef PHASECOMP_BYPASS_EN
    .bypass (bypass),
`endif
    .s_axis (s_if),
    .m_axis (m_if)
  );

  typedef struct {
    int data;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   in_q[$];
  exp_t e;
  bit   fbyp;
  int   mshift, sh;
  int   nvec = 0, nerr = 0;
  int   out_cnt = 0, acc_tot = 0, trk_n = 0;
  int   out_log [2048];
  bit   last_log[2048];
  int   cyc = 0, t_acc64 = 0, t_vld = 0, bubbles = 0;
  bit   seen_vld = 0, acc_seen = 0, prev_stall = 0;
  logic [WIDTH-1:0] prev_data;
  logic             prev_last;
  int   val = 0, left = 0, src_pct = 0, snk_pct = 0, byp_lo = 0, byp_hi = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Reference: gather each completed input frame into output order, out[a] = in[(a - shift) mod N].
  always @(negedge clk) begin
    cyc++;
    acc_seen = rst && s_if.tvalid && s_if.tready;
    if (!rst) begin
      chk("tready_in_reset", 32'(s_if.tready), 0);
      exp_q.delete();
      in_q.delete();
      mshift     = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_tvalid", 32'(m_if.tvalid), 1);
        chk("stall_tdata", 32'(m_if.tdata), 32'(prev_data));
        chk("stall_tlast", 32'(m_if.tlast), 32'(prev_last));
      end
      if (acc_seen) begin
`ifdef PHASECOMP_BYPASS_EN
        if (in_q.size() == 0) fbyp = bypass;
`else
        if (in_q.size() == 0) fbyp = 1'b0;
`endif
        in_q.push_back(int'(s_if.tdata));
        acc_tot++;
        if (acc_tot == N) t_acc64 = cyc;
        if (in_q.size() == N) begin
          sh = fbyp ? 0 : mshift;
          for (int a = 0; a < N; a++) begin
            e.data = in_q[(a - sh + N) % N];
            e.last = (a == N - 1);
            exp_q.push_back(e);
          end
          mshift = (mshift + DEC_FAC) % N;
          in_q.delete();
        end
      end
      if (m_if.tvalid === 1'b1) begin
        if (!seen_vld) begin
          seen_vld = 1'b1;
          t_vld    = cyc;
        end
      end else if (seen_vld && out_cnt < trk_n) begin
        bubbles++;
      end
      if (m_if.tvalid && m_if.tready) begin
        chk("out_available", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_data", 32'(m_if.tdata), 32'(e.data));
          chk("out_last", 32'(m_if.tlast), 32'(e.last));
        end
        if (out_cnt < 2048) begin
          out_log[out_cnt]  = int'(m_if.tdata);
          last_log[out_cnt] = m_if.tlast;
        end
        out_cnt++;
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_data  = m_if.tdata;
      prev_last  = m_if.tlast;
    end
  end

  // Source/sink driver: ramp values, tvalid held until accepted.
  initial begin : drv
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (acc_seen) begin
        val++;
        left--;
      end
      if (!(s_if.tvalid && !acc_seen && left > 0))
        s_if.tvalid = (left > 0) && (int'($urandom_range(99)) < src_pct);
      s_if.tdata  = WIDTH'(val);
      m_if.tready = int'($urandom_range(99)) < snk_pct;
`ifdef PHASECOMP_BYPASS_EN
      bypass = (val >= byp_lo) && (val < byp_hi);
`endif
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0; left = 0; src_pct = 0; snk_pct = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1; out_cnt = 0; acc_tot = 0; seen_vld = 0; bubbles = 0; trk_n = 0;
  endtask

  task automatic wait_out(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (out_cnt < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk(nm, 32'(out_cnt >= n), 1);
  endtask

  initial begin : main
    int k;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tvalid", 32'(m_if.tvalid), 0);
    chk("rst_tlast", 32'(m_if.tlast), 0);
    chk("rst_tdata", 32'(m_if.tdata), 0);
    chk("rst_tready", 32'(s_if.tready), 0);
    rst = 1'b1;
    #1;
    chk("post_rst_tready", 32'(s_if.tready), 1);

    // Continuous ramp through a full cycle of phase states.
    val = 0; left = 5 * N; src_pct = 100; snk_pct = 100; trk_n = 5 * N;
    wait_out(5 * N, 2000, "ramp_done");
    chk("ramp_f0_0", 32'(out_log[0]), 0);
    chk("ramp_f0_1", 32'(out_log[1]), 1);
    chk("ramp_f0_2", 32'(out_log[2]), 2);
    chk("ramp_f1_0", 32'(out_log[64]), 80);
    chk("ramp_f1_47", 32'(out_log[64 + 47]), 127);
    chk("ramp_f1_48", 32'(out_log[64 + 48]), 64);
    chk("ramp_f2_0", 32'(out_log[128]), 160);
    chk("ramp_f3_0", 32'(out_log[192]), 240);
    chk("ramp_f4_0", 32'(out_log[256]), 256);
    chk("ramp_tlast_63", 32'(last_log[63]), 1);
    chk("ramp_tlast_127", 32'(last_log[127]), 1);
    chk("ramp_tlast_191", 32'(last_log[191]), 1);
    chk("ramp_tlast_64", 32'(last_log[64]), 0);
    chk("ramp_bubbles", 32'(bubbles), 0);
    // 64th accept seen one negedge before its edge; tvalid appears two edges later.
    chk("ramp_latency", 32'(t_vld - t_acc64), 3);

    // Output stalled: two banks fill, then input backs off.
    do_reset();
    val = 0; left = 200; src_pct = 100; snk_pct = 0;
    repeat (250) @(posedge clk);
    #2;
    chk("bp_accepted", 32'(acc_tot), 128);
    chk("bp_tready", 32'(s_if.tready), 0);
    chk("bp_tvalid", 32'(m_if.tvalid), 1);
    chk("bp_tdata", 32'(m_if.tdata), 0);
    snk_pct = 100;
    wait_out(3 * N, 1000, "bp_done");
    chk("bp_f0_0", 32'(out_log[0]), 0);
    chk("bp_f0_63", 32'(out_log[63]), 63);
    chk("bp_f1_0", 32'(out_log[64]), 80);
    chk("bp_f2_0", 32'(out_log[128]), 160);

    // Reset in the middle of the second frame.
    do_reset();
    val = 0; left = 1000; src_pct = 100; snk_pct = 100;
    k = 0;
    while (acc_tot < 100 && k < 500) begin
      @(posedge clk);
      k++;
    end
    chk("mid_reach_100", 32'(acc_tot >= 100), 1);
    #2;
    rst = 1'b0; left = 0;
    @(posedge clk); #2;
    chk("mid_rst_tvalid", 32'(m_if.tvalid), 0);
    rst = 1'b1; val = 500; left = N; out_cnt = 0; acc_tot = 0;
    wait_out(N, 500, "mid_done");
    chk("mid_first", 32'(out_log[0]), 500);
    chk("mid_last", 32'(out_log[N - 1]), 500 + N - 1);
    chk("mid_tlast", 32'(last_log[N - 1]), 1);

    // Random handshakes over 16 frames.
    do_reset();
    val = 1000; left = 16 * N; src_pct = 50; snk_pct = 50;
    wait_out(16 * N, 20000, "rnd_done");
    repeat (4) @(posedge clk);
    chk("rnd_drained", 32'(exp_q.size()), 0);
    chk("rnd_count", 32'(out_cnt), 16 * N);

`ifdef PHASECOMP_BYPASS_EN
    do_reset();
    val = 0; byp_lo = 64; byp_hi = 128; left = 3 * N; src_pct = 100; snk_pct = 100;
    wait_out(3 * N, 1000, "byp_done");
    chk("byp_f0_0", 32'(out_log[0]), 0);
    chk("byp_f1_0", 32'(out_log[64]), 64);
    chk("byp_f2_0", 32'(out_log[128]), 160);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/phasecomp_buffer.md
Name: phasecomp_buffer

Overview:
- Phase-compensation circular-shift buffer between the OSPFB polyphase FIR output and the FFT input.
- Each FIR output frame of FFT_LEN samples must be circularly rotated by a state-dependent offset before the FFT. This corrects the phase rotation introduced by decimating by DEC_FAC < FFT_LEN.
- Ping-pong buffered: one frame is written while the previous one streams out in natural order.

Parameters:
- WIDTH, 16, sample width in bits (complex or real packed; treated opaquely).
- FFT_LEN, 64, frame length; power of two.
- DEC_FAC, 48, decimation factor; 0 < DEC_FAC <= FFT_LEN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; active-low and synchronous (sampled on rising clk).
- s_axis_tdata  in  WIDTH  FIR output sample.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tready  out  1  buffer can accept a sample.
- m_axis_tdata  out  WIDTH  rotated sample to FFT.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  FFT accepts.
- m_axis_tlast  out  1  last sample of an output frame.

Behaviour:
- Reset (rst=0 at posedge): both bank-full flags cleared; write bank=0, wr_idx=0, shift=0; read bank=0, read FSM=IDLE.
- Outputs during/after reset: s_axis_tready=0 while rst=0, then 1; m_axis_tvalid=0; m_axis_tlast=0; m_axis_tdata=0.
- Reset mid-frame discards all buffered and partial frames. No partial output is emitted.
- Write side:
  - A sample is accepted when s_axis_tvalid && s_axis_tready.
  - It is stored at bank[wr_bank][(wr_idx + shift) mod FFT_LEN].
  - wr_idx increments on each accept. When wr_idx wraps from FFT_LEN-1 to 0: set full[wr_bank], toggle wr_bank, and update shift <= (shift + DEC_FAC) mod FFT_LEN.
  - This gives FFT_LEN/gcd(FFT_LEN,DEC_FAC) states; for 64/48 the sequence is 0,48,32,16,0.
  - s_axis_tready = !full[wr_bank].
- Read FSM:
  - IDLE -> PRIME when full[rd_bank]. PRIME issues the RAM read of address 0 (1-cycle RAM latency).
  - PRIME -> STREAM. In STREAM, m_axis_tvalid=1, data is registered, and the next address is prefetched only on handshake.
  - Output is in natural order 0..FFT_LEN-1. m_axis_tlast=1 on address FFT_LEN-1.
  - On the tlast handshake: clear full[rd_bank], toggle rd_bank, go to PRIME if the other bank is full, else IDLE.
  - Gap-free streaming across frames: the next frame's first sample is ready the cycle after tlast. PRIME overlaps with the tlast handshake.
  - m_axis_tdata, m_axis_tvalid and m_axis_tlast hold stable while m_axis_tvalid && !m_axis_tready.
- Latency: first m_axis_tvalid is asserted 2 cycles after the posedge that accepts the last sample of a frame into an empty-read-side buffer.
- Full/empty:
  - With both banks full, s_axis_tready=0.
  - If a full flag is cleared by tlast in the same cycle the writer wraps onto that bank, full[] is registered. s_axis_tready rises the cycle after the clear; no sample is lost or overwritten.
  - A simultaneous set (writer) and clear (reader) of different banks are independent.
- Arithmetic: address and shift use ADDR_W=$clog2(FFT_LEN) bits with natural modular wrap; DEC_FAC is reduced mod FFT_LEN at elaboration.

Optional Feature:
- Macro PHASECOMP_BYPASS_EN.
- Defined: adds input port bypass (1 bit), sampled only at frame boundaries (wr_idx==0). When 1, that frame is written with shift treated as 0 and the shift state still advances; buffering and latency are unchanged.
- Undefined: port absent; rotation always applied.

Decomposition:
- Shared package alpaca_ospfb_utils_pkg gains:
  - ADDR_W
  - NUM_PHASE_STATES = FFT_LEN/gcd(FFT_LEN,DEC_FAC)
  - enum rd_state_t {IDLE, PRIME, STREAM}
- FFT_LEN, DEC_FAC and WIDTH are reused from the package.
- One sub-module: phasecomp_bank, a simple dual-port RAM of depth 2*FFT_LEN (bank bit as address MSB), 1-cycle registered read.

Test Plan:
- Ramp, continuous flow: in = frame*64+n, tready=1 -> out frame0[0..2]=0,1,2; frame1[0]=80, frame1[47]=127, frame1[48]=64; frame2[0]=160; frame3[0]=240; frame4[0]=256 (state wrap).
- tlast timing: tlast asserted exactly on output samples 63, 127, 191; no bubbles between frames under continuous input.
- Backpressure: m_axis_tready=0, tvalid=1 continuous -> samples 0..127 accepted, s_axis_tready=0 from sample 128. Raise tready -> output 0..63 then frame1 rotated (first=80). tdata stable during stall.
- Random tvalid/tready (50%) over 16 frames -> output matches a scoreboard model of (n+shift) rotation; no drop or duplicate.
- Reset mid-frame: assert rst=0 for 1 cycle at input sample 100 -> m_axis_tvalid=0 next cycle. Next 64 inputs, starting at value 500, emerge unrotated starting with 500.
- PHASECOMP_BYPASS_EN build: bypass=1 during frame1 -> frame1 out[0]=64; frame2 out[0]=160 (state kept advancing).
